pe_seq_ctrl: RTL

//  Sequencer on the driving side of a single PE (clk/rst/pe_in/pe_filter/mode_i/activate -> pe_out).

---
 rtl/pe_seq_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// Job sequencer that drives one PE's inputs and streams its results back through a small FIFO.
// Optional PE_SEQ_RELU_EN: clamp negative (signed) PE results to zero before they are stored.
`timescale 1ns/1ps
module pe_seq_ctrl #(
    parameter int DW         = 8,
    parameter int CW         = 5,
    parameter int PE_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [CW-1:0] cmd_len,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [DW-1:0] op_in,
    input  logic [DW-1:0] op_filter,
    output logic [DW-1:0] pe_in_drv,
    output logic [DW-1:0] pe_filter_drv,
    output logic [1:0]    pe_mode,
    output logic          pe_activate,
    input  logic [DW-1:0] pe_result,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          busy,
    output logic          done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 2;
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SA     = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ACT, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   left_q, left_d;
    logic [DW-1:0]   in_q, in_d;
    logic [DW-1:0]   filt_q, filt_d;
    logic [1:0]      pmode_q, pmode_d;
    logic            act_q, act_d;
    logic [PE_LAT:0] beat_q, beat_d;
    logic [PE_LAT:0] tag_q, tag_d;
    logic [AW:0]     wr_q, rd_q, cnt_raw;
    logic [NW-1:0]   fifo_cnt, inflight;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic            fire, last_beat, want_tag, push, pop;

`ifdef PE_SEQ_RELU_EN
    function automatic logic [DW-1:0] store_f(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction
`else
    function automatic logic [DW-1:0] store_f(input logic [DW-1:0] x);
        return x;
    endfunction
`endif

    // Pipe stage 0 is the beat sitting on the PE inputs; stage PE_LAT is its result on pe_result.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PE_LAT; i++) begin
            inflight = inflight + NW'(tag_q[i]);
        end
    end

    assign cnt_raw   = wr_q - rd_q;
    assign fifo_cnt  = NW'(cnt_raw);
    assign res_valid = (wr_q != rd_q);
    assign res_data  = res_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign pop       = res_valid & res_ready;
    assign push      = tag_q[PE_LAT];

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign op_ready  = (state_q == S_FEED) && (left_q != '0) &&
                       ((fifo_cnt + inflight) < NW'(FIFO_DEPTH));
    assign fire      = op_valid & op_ready;
    assign last_beat = (left_q == CW'(1));
    assign want_tag  = fire & ((mode_q == MODE_SA) | ((mode_q == MODE_SINGLE) & last_beat));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d = cmd_mode;
                    if ((cmd_len == '0) || (cmd_mode == MODE_HOLD)) begin
                        left_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        left_d  = cmd_len;
                        state_d = S_ACT;
                    end
                end
            end
            S_ACT:   state_d = S_FEED;
            S_FEED: begin
                if (fire) begin
                    left_d = left_q - CW'(1);
                    if (last_beat) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (beat_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_d    = fire ? op_in : in_q;
        filt_d  = fire ? op_filter : filt_q;
        pmode_d = fire ? mode_q : MODE_HOLD;
        beat_d  = {beat_q[PE_LAT-1:0], fire};
        tag_d   = {tag_q[PE_LAT-1:0], want_tag};
        // A job skipped straight to DONE never touches the PE.
        act_d   = (state_d inside {S_ACT, S_FEED, S_DRAIN}) ||
                  ((state_d == S_DONE) && (state_q == S_DRAIN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            left_q  <= '0;
            in_q    <= '0;
            filt_q  <= '0;
            pmode_q <= MODE_HOLD;
            act_q   <= 1'b0;
            beat_q  <= '0;
            tag_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            left_q  <= left_d;
            in_q    <= in_d;
            filt_q  <= filt_d;
            pmode_q <= pmode_d;
            act_q   <= act_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= store_f(pe_result);
    end

    assign pe_in_drv     = in_q;
    assign pe_filter_drv = filt_q;
    assign pe_mode       = pmode_q;
    assign pe_activate   = act_q;
endmodule
